qos_scheduler: RTL and testbench
================================

// Module: qos_scheduler
// PURPOSE
//  Output-side scheduler for the QoS block: decides each cycle which of the QUEUE_QUANTITY
//  virtual-channel FIFOs is popped onto dataOut.
//  Supports three disciplines selected by mem_seleccion_roundRobin: simple RR, weighted RR,
//  and table-driven arbitration.
//  Sits between the FIFO bank (consumes empty flags) and the output mux (drives pop/sel_vc).
// PARAMETERS
//  QUEUE_QUANTITY    4   number of VC FIFOs (power of 2)
//  MAX_WEIGHT        64  weight range; weight fields are $clog2(MAX_WEIGHT)=6 bits
//  TABLE_SIZE        8   entries in arbitration table (power of 2)
//  TIPOS_ROUND_ROBIN 3   number of scheduling modes
// PORTS
//  clk                      in   1       clock, rising edge
//  rst                      in   1       asynchronous, active-low reset
//  enb                      in   1       enable; 0 freezes all state, forces pop=0
//  iniciar                  in   1       pulse: (re)latch configuration, restart pointers
//  empty                    in   Q       per-FIFO empty flags, same-cycle
//  mem_seleccion_roundRobin in   2       mode: 0 simple RR, 1 weighted RR, 2 table, 3 -> treated as 0
//  mem_pesos                in   Q*6     per-queue weight, queue i at [6i+:6]
//  mem_pesosArbitraje       in   T*6     per-entry grant count, entry j at [6j+:6]
//  mem_selecciones          in   T*2     per-entry queue id, entry j at [2j+:2]
//  pop                      out  Q       one-hot read strobe to FIFO bank (Mealy)
//  sel_vc                   out  2       queue id of current pop; holds last value when valid=0
//  valid                    out  1       pop issued this cycle
//  idle                     out  1       no eligible queue, or not in RUN
//  grant_count              out  Q*16    per-queue grant counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, all pointers/credits=0, config regs=0, pop=0, sel_vc=0,
//   valid=0, idle=1, grant_count=0.
//  FSM: IDLE --iniciar--> CONFIG (1 cycle: latch mode, weights, table; clear ptrs/credit) --> RUN.
//   An iniciar pulse while in RUN --> CONFIG. Inputs mem_* are ignored outside CONFIG.
//  Eligible queue: empty[q]=0 and, in mode 1, weight[q]!=0. Eligible table entry: weight!=0
//   and its queue is non-empty.
//  Grant is combinational from registered ptr/credit and current empty, which means zero-cycle
//   latency and guarantees no pop of an empty FIFO. State advances on the clock edge only when
//   enb=1.
//  Mode 0: rotating priority starting at qptr; on grant q, qptr<=q+1 (mod Q).
//  Mode 1: serve the first eligible queue starting at qptr.
//   Fresh grant (credit=0) with weight 1: qptr<=q+1.
//   Fresh grant with weight w>1: credit<=w-1, qptr stays at q.
//   Grant with credit>0: credit<=credit-1; when credit reaches 0, qptr<=q+1.
//   If qptr's queue is ineligible, the search moves on and credit is cleared (no banking).
//  Mode 2: rotating search over entries from tptr, same credit rule using
//   mem_pesosArbitraje[j]; the granted queue is mem_selecciones[j]. tptr wraps T-1 -> 0.
//  No eligible queue/entry: pop=0, valid=0, idle=1, pointers and credit unchanged.
//  enb=0: pop=0, valid=0, state held; idle is still computed.
//  Reset mid-burst aborts immediately; outputs go to reset values the same instant.
//  Credit is 6 bits; weight 63 yields 63 consecutive grants, never 64.
// CONFIGURATION
//  QOS_SCHED_STATS_EN defined:
//   - grant_count[16i+:16] increments on each pop[i]; saturates at 16'hFFFF.
//   - Counters clear on reset and in CONFIG.
//  Not defined: grant_count is tied to 0 and no counter flops are synthesised.
// STRUCTURE
//  Shared package qos_pkg:
//   - mode encodings RR_SIMPLE=0, RR_WEIGHTED=1, RR_TABLE=2
//   - FSM encodings S_IDLE, S_CONFIG, S_RUN
//   - width constants W_BITS=$clog2(MAX_WEIGHT), Q_BITS=$clog2(QUEUE_QUANTITY)
//  Sub-module rr_prio_picker (N, request vector, start pointer -> found, index): rotating
//   priority encoder, instantiated once for queues (N=Q) and once for table entries (N=T).
// TESTING
//  1 Reset/idle: rst=0 with empty=4'b0000 -> pop=0, idle=1; release, no iniciar -> pop stays 0.
//  2 Mode 0: all non-empty -> sel_vc 0,1,2,3,0...; with empty=4'b0101 -> sel_vc 1,3,1,3.
//  3 Mode 1: weights {1,2,3,0}, all non-empty -> sel_vc 0,1,1,2,2,2,0...; queue 3 never popped.
//  4 Mode 2: table {(q2,w2),(q0,w1),(q1,w0),(q3,w1)}, rest w0 -> sel_vc 2,2,0,3,2,2...
//  5 Boundary: mode 1, w[1]=5, empty[1] rises after 2 grants -> move to q2 same cycle,
//    credit cleared; q1 refilled later -> fresh 5-grant burst. enb=0 for 3 cycles -> no pop,
//    sequence resumes unchanged.
//  6 QOS_SCHED_STATS_EN: 100 grants in mode 0 -> grant_count each 25; iniciar clears to 0.
//    Every test checks the scoreboard rule pop & empty == 0 on every cycle.

Source files
------------

// File: rtl/qos_scheduler_pkg.sv
// Shared encodings and default sizes for the QoS output scheduler.
package qos_pkg;
  localparam int DEF_Q     = 4;
  localparam int DEF_MAX_W = 64;
  localparam int DEF_T     = 8;
  localparam int W_BITS    = $clog2(DEF_MAX_W);
  localparam int Q_BITS    = $clog2(DEF_Q);

  typedef enum logic [1:0] {RR_SIMPLE = 2'd0, RR_WEIGHTED = 2'd1, RR_TABLE = 2'd2} rr_mode_e;
  typedef enum logic [1:0] {S_IDLE, S_CONFIG, S_RUN} state_e;
endpackage

// File: rtl/qos_scheduler_if.sv
// Scheduler bus: FIFO-bank flags and configuration in, pop/select/status out.
interface qos_scheduler_if #(
  parameter int QUEUE_QUANTITY = qos_pkg::DEF_Q,
  parameter int MAX_WEIGHT     = qos_pkg::DEF_MAX_W,
  parameter int TABLE_SIZE     = qos_pkg::DEF_T
);
  localparam int WB = $clog2(MAX_WEIGHT);
  localparam int QB = $clog2(QUEUE_QUANTITY);

  logic                         enb;
  logic                         iniciar;
  logic [QUEUE_QUANTITY-1:0]    empty;
  logic [1:0]                   mem_seleccion_roundRobin;
  logic [QUEUE_QUANTITY*WB-1:0] mem_pesos;
  logic [TABLE_SIZE*WB-1:0]     mem_pesosArbitraje;
  logic [TABLE_SIZE*QB-1:0]     mem_selecciones;
  logic [QUEUE_QUANTITY-1:0]    pop;
  logic [QB-1:0]                sel_vc;
  logic                         valid;
  logic                         idle;
  logic [QUEUE_QUANTITY*16-1:0] grant_count;

  modport master (
    output enb, iniciar, empty, mem_seleccion_roundRobin, mem_pesos, mem_pesosArbitraje, mem_selecciones,
    input  pop, sel_vc, valid, idle, grant_count
  );
  modport slave (
    input  enb, iniciar, empty, mem_seleccion_roundRobin, mem_pesos, mem_pesosArbitraje, mem_selecciones,
    output pop, sel_vc, valid, idle, grant_count
  );
endinterface

// File: rtl/qos_scheduler_rr_prio_picker.sv
// Rotating priority encoder: first set request at or after start, wrapping (N power of 2).
module rr_prio_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] k;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = start + IW'(i);
      if (req[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end
endmodule

// File: rtl/qos_scheduler.sv
// QoS output scheduler: simple RR, weighted RR and table arbitration over the VC FIFOs.
// Optional per-queue grant counters are built when QOS_SCHED_STATS_EN is defined.
module qos_scheduler import qos_pkg::*; #(
  parameter int QUEUE_QUANTITY = DEF_Q,
  parameter int MAX_WEIGHT     = DEF_MAX_W,
  parameter int TABLE_SIZE     = DEF_T
) (
  input logic            clk,
  input logic            rst,
  qos_scheduler_if.slave bus
);
  localparam int Q     = QUEUE_QUANTITY;
  localparam int T     = TABLE_SIZE;
  localparam int WB    = $clog2(MAX_WEIGHT);
  localparam int QB    = $clog2(Q);
  localparam int TBITS = $clog2(T);

  state_e                state, state_nx;
  rr_mode_e              mode;
  logic [Q-1:0][WB-1:0]  weight;
  logic [T-1:0][WB-1:0]  tw;
  logic [T-1:0][QB-1:0]  tsel;
  logic [QB-1:0]         qptr, last_q, q_idx, gq;
  logic [TBITS-1:0]      tptr, t_idx;
  logic [WB-1:0]         credit, held, cur_w, rem;
  logic [Q-1:0]          q_req, pop_w;
  logic [T-1:0]          t_req;
  logic                  q_found, t_found, found, run, grant;

  always_ff @(posedge clk or negedge rst)
    if (!rst)         state <= S_IDLE;
    else if (bus.enb) state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (bus.iniciar) state_nx = S_CONFIG;
      S_CONFIG: state_nx = S_RUN;
      S_RUN:    if (bus.iniciar) state_nx = S_CONFIG;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    q_req = '0;
    t_req = '0;
    for (int i = 0; i < Q; i++) q_req[i] = !bus.empty[i] && (mode != RR_WEIGHTED || weight[i] != '0);
    for (int j = 0; j < T; j++) t_req[j] = (tw[j] != '0) && !bus.empty[tsel[j]];
  end

  rr_prio_picker #(.N(Q)) u_qpick (.req(q_req), .start(qptr), .found(q_found), .idx(q_idx));
  rr_prio_picker #(.N(T)) u_tpick (.req(t_req), .start(tptr), .found(t_found), .idx(t_idx));

  // Credit only survives when the pointed item is the one served; a skip starts a fresh burst.
  always_comb begin
    if (mode == RR_TABLE) begin
      found = t_found;
      gq    = tsel[t_idx];
      cur_w = tw[t_idx];
      held  = (t_idx == tptr) ? credit : '0;
    end else begin
      found = q_found;
      gq    = q_idx;
      cur_w = (mode == RR_WEIGHTED) ? weight[q_idx] : WB'(1);
      held  = (mode == RR_WEIGHTED && q_idx == qptr) ? credit : '0;
    end
    rem   = (held != '0) ? held - 1'b1 : cur_w - 1'b1;
    run   = (state == S_RUN);
    grant = run && found && bus.enb;
    pop_w = '0;
    for (int i = 0; i < Q; i++) pop_w[i] = grant && (gq == QB'(i));
  end

  assign bus.pop    = pop_w;
  assign bus.valid  = grant;
  assign bus.sel_vc = grant ? gq : last_q;
  assign bus.idle   = !(run && found);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mode   <= RR_SIMPLE;
      weight <= '0;
      tw     <= '0;
      tsel   <= '0;
      qptr   <= '0;
      tptr   <= '0;
      credit <= '0;
      last_q <= '0;
    end else if (bus.enb) begin
      if (state == S_CONFIG) begin
        case (bus.mem_seleccion_roundRobin)
          2'd1:    mode <= RR_WEIGHTED;
          2'd2:    mode <= RR_TABLE;
          default: mode <= RR_SIMPLE;
        endcase
        weight <= bus.mem_pesos;
        tw     <= bus.mem_pesosArbitraje;
        tsel   <= bus.mem_selecciones;
        qptr   <= '0;
        tptr   <= '0;
        credit <= '0;
      end else if (grant) begin
        credit <= rem;
        last_q <= gq;
        if (mode == RR_TABLE) tptr <= (rem == '0) ? t_idx + 1'b1 : t_idx;
        else                  qptr <= (rem == '0) ? q_idx + 1'b1 : q_idx;
      end
    end

`ifdef QOS_SCHED_STATS_EN
  logic [Q-1:0][15:0] gcnt;

  always_ff @(posedge clk or negedge rst)
    if (!rst) gcnt <= '0;
    else if (bus.enb) begin
      if (state == S_CONFIG) gcnt <= '0;
      else
        for (int i = 0; i < Q; i++)
          if (pop_w[i] && gcnt[i] != 16'hFFFF) gcnt[i] <= gcnt[i] + 16'd1;
    end

  assign bus.grant_count = gcnt;
`else
  assign bus.grant_count = '0;
`endif
endmodule

// File: tb/tb_qos_scheduler.sv
// Randomized + directed bench for qos_scheduler against a queue-level scheduling model.
module tb_qos_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  qos_scheduler_if bi ();
  qos_scheduler dut (.clk(clk), .rst(rst), .bus(bi.slave));

  int n_chk = 0, n_fail = 0;

  // Model: phase 0 idle / 1 config / 2 run; m_left = grants still owed to the pointed item.
  int ph = 0, m_mode = 0, m_ptr = 0, m_tptr = 0, m_left = 0, m_last = 0;
  int m_w[4], m_tw[8], m_ts[8], m_cnt[4];
  bit e_found, e_valid;
  int e_idx, e_q, e_left_new;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; m_mode = 0; m_ptr = 0; m_tptr = 0; m_left = 0; m_last = 0;
    for (int i = 0; i < 4; i++) begin m_w[i] = 0; m_cnt[i] = 0; end
    for (int j = 0; j < 8; j++) begin m_tw[j] = 0; m_ts[j] = 0; end
  endtask

  function automatic bit elig(input int i);
    if (m_mode == 2) return m_tw[i] != 0 && !bi.empty[m_ts[i]];
    if (m_mode == 1) return m_w[i] != 0 && !bi.empty[i];
    return !bi.empty[i];
  endfunction

  task automatic model_eval();
    int n, base, w, k;
    e_found = 0; e_idx = 0; e_q = m_last; e_left_new = 0; k = 0;
    if (ph == 2) begin
      n    = (m_mode == 2) ? 8 : 4;
      base = (m_mode == 2) ? m_tptr : m_ptr;
      for (int o = 0; o < n; o++)
        if (!e_found && elig((base + o) % n)) begin
          e_found = 1; e_idx = (base + o) % n; k = o;
        end
      if (e_found) begin
        e_q = (m_mode == 2) ? m_ts[e_idx] : e_idx;
        w   = (m_mode == 2) ? m_tw[e_idx] : (m_mode == 1 ? m_w[e_idx] : 1);
        e_left_new = (k != 0 || m_left == 0) ? w - 1 : m_left - 1;
      end
    end
    e_valid = e_found && bi.enb;
  endtask

  task automatic model_edge();
    int n;
    if (!bi.enb) return;
    if (ph == 2 && e_valid) begin
      n = (m_mode == 2) ? 8 : 4;
      m_left = e_left_new;
      if (m_mode == 2) m_tptr = (m_left == 0) ? (e_idx + 1) % n : e_idx;
      else             m_ptr  = (m_left == 0) ? (e_idx + 1) % n : e_idx;
      m_last = e_q;
      if (m_cnt[e_q] < 65535) m_cnt[e_q]++;
    end
    if (ph == 1) begin
      case (bi.mem_seleccion_roundRobin)
        2'd1: m_mode = 1;
        2'd2: m_mode = 2;
        default: m_mode = 0;
      endcase
      for (int i = 0; i < 4; i++) begin m_w[i] = int'(bi.mem_pesos[6*i+:6]); m_cnt[i] = 0; end
      for (int j = 0; j < 8; j++) begin
        m_tw[j] = int'(bi.mem_pesosArbitraje[6*j+:6]);
        m_ts[j] = int'(bi.mem_selecciones[2*j+:2]);
      end
      m_ptr = 0; m_tptr = 0; m_left = 0; ph = 2;
    end else if (bi.iniciar) ph = 1;
  endtask

  // xs >= 0: also require a grant to that queue; xs == -2: require no grant.
  task automatic cycle(input int xs = -1);
    logic [3:0] one;
    one = 4'b0001;
    #1;
    model_eval();
    chk("valid", bi.valid, e_valid);
    chk("idle", bi.idle, !e_found);
    chk("pop", bi.pop, e_valid ? (one << e_q) : 4'b0000);
    chk("sel_vc", bi.sel_vc, e_valid ? e_q : m_last);
    chk("pop_of_empty", bi.pop & bi.empty, 4'b0000);
    for (int i = 0; i < 4; i++)
`ifdef QOS_SCHED_STATS_EN
      chk("grant_count", bi.grant_count[16*i+:16], m_cnt[i]);
`else
      chk("grant_count", bi.grant_count[16*i+:16], 0);
`endif
    if (xs >= 0) begin
      chk("seq_sel", bi.sel_vc, xs);
      chk("seq_valid", bi.valid, 1);
    end else if (xs == -2) chk("seq_valid", bi.valid, 0);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic configure(input logic [1:0] md, input logic [23:0] pw, input logic [47:0] tw,
                           input logic [15:0] ts);
    bi.enb = 1'b1;
    bi.empty = 4'b1111;
    bi.mem_seleccion_roundRobin = md;
    bi.mem_pesos = pw;
    bi.mem_pesosArbitraje = tw;
    bi.mem_selecciones = ts;
    bi.iniciar = 1'b1;
    cycle();
    bi.iniciar = 1'b0;
    cycle();
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 4; i++)
      bi.mem_pesos[6*i+:6] = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 4));
    for (int j = 0; j < 8; j++) begin
      bi.mem_pesosArbitraje[6*j+:6] = 6'($urandom_range(0, 3));
      bi.mem_selecciones[2*j+:2]    = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    model_reset();
    bi.enb = 1'b1; bi.iniciar = 1'b0; bi.empty = 4'b0000;
    bi.mem_seleccion_roundRobin = 2'd0; bi.mem_pesos = '0;
    bi.mem_pesosArbitraje = '0; bi.mem_selecciones = '0;

    // Reset and idle without iniciar
    #12;
    chk("rst_pop", bi.pop, 4'b0000);
    chk("rst_idle", bi.idle, 1);
    chk("rst_valid", bi.valid, 0);
    chk("rst_sel", bi.sel_vc, 0);
    chk("rst_gcnt", bi.grant_count, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) cycle(-2);

    // Mode 0
    configure(2'd0, '0, '0, '0);
    bi.empty = 4'b0000;
    cycle(0); cycle(1); cycle(2); cycle(3); cycle(0);
    bi.empty = 4'b0101;
    cycle(1); cycle(3); cycle(1); cycle(3);

    // Mode 1, weights q0..q3 = 1,2,3,0
    configure(2'd1, {6'd0, 6'd3, 6'd2, 6'd1}, '0, '0);
    bi.empty = 4'b0000;
    cycle(0); cycle(1); cycle(1); cycle(2); cycle(2); cycle(2); cycle(0); cycle(1); cycle(1); cycle(2);

    // Mode 2 table
    configure(2'd2, '0, {24'd0, 6'd1, 6'd0, 6'd1, 6'd2}, {8'd0, 2'd3, 2'd1, 2'd0, 2'd2});
    bi.empty = 4'b0000;
    cycle(2); cycle(2); cycle(0); cycle(3); cycle(2); cycle(2); cycle(0); cycle(3);

    // Burst interrupted by empty, refilled, and paused by enb
    configure(2'd1, {6'd1, 6'd1, 6'd5, 6'd1}, '0, '0);
    bi.empty = 4'b0000;
    cycle(0); cycle(1); cycle(1);
    bi.empty = 4'b0010;
    cycle(2); cycle(3); cycle(0);
    bi.empty = 4'b0000;
    cycle(1); cycle(1);
    bi.enb = 1'b0;
    cycle(-2); cycle(-2); cycle(-2);
    bi.enb = 1'b1;
    cycle(1); cycle(1); cycle(1); cycle(2); cycle(3);

    // Asynchronous reset mid-burst
    cycle(0); cycle(1);
    rst = 1'b0;
    #1;
    chk("midrst_pop", bi.pop, 4'b0000);
    chk("midrst_valid", bi.valid, 0);
    chk("midrst_idle", bi.idle, 1);
    chk("midrst_sel", bi.sel_vc, 0);
    chk("midrst_gcnt", bi.grant_count, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cycle(-2); cycle(-2);

    // Grant statistics
    configure(2'd0, '0, '0, '0);
    bi.empty = 4'b0000;
    repeat (100) cycle();
`ifdef QOS_SCHED_STATS_EN
    for (int i = 0; i < 4; i++) chk("stats_100", bi.grant_count[16*i+:16], 25);
    configure(2'd0, '0, '0, '0);
    for (int i = 0; i < 4; i++) chk("stats_clear", bi.grant_count[16*i+:16], 0);
`else
    chk("stats_off", bi.grant_count, 0);
`endif

    // Random configurations and traffic; mem_* churns to show it is ignored in RUN
    for (int r = 0; r < 12; r++) begin
      rand_mem();
      configure(2'($urandom_range(0, 3)), bi.mem_pesos, bi.mem_pesosArbitraje, bi.mem_selecciones);
      for (int c = 0; c < 150; c++) begin
        for (int i = 0; i < 4; i++) bi.empty[i] = ($urandom_range(0, 9) < 4);
        bi.enb = ($urandom_range(0, 9) != 0);
        bi.mem_seleccion_roundRobin = 2'($urandom_range(0, 3));
        rand_mem();
        cycle();
      end
      bi.enb = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
